// File: rtl/amm_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : amm_master_arbiter_if
// Summary  : Bundle of the two requester ports, the shared Avalon-MM master
//            port and the timeout flag of amm_master_arbiter.
//            The master modport is the arbiter's view; slave is the view of
//            the surrounding logic (requesters plus the downstream slave).
// Revision : 1.0 - initial release
// ============================================================================
interface amm_master_arbiter_if #(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32
);
  // Requester 0
  logic [ADDRESSWIDTH-1:0] r0_address;
  logic [DATAWIDTH-1:0]    r0_writedata;
  logic                    r0_write;
  logic                    r0_read;
  logic                    r0_waitrequest;
  logic [DATAWIDTH-1:0]    r0_readdata;
  logic                    r0_readdatavalid;
  // Requester 1
  logic [ADDRESSWIDTH-1:0] r1_address;
  logic [DATAWIDTH-1:0]    r1_writedata;
  logic                    r1_write;
  logic                    r1_read;
  logic                    r1_waitrequest;
  logic [DATAWIDTH-1:0]    r1_readdata;
  logic                    r1_readdatavalid;
  // Shared master port
  logic [ADDRESSWIDTH-1:0] master_address;
  logic [DATAWIDTH-1:0]    master_writedata;
  logic                    master_write;
  logic                    master_read;
  logic [DATAWIDTH-1:0]    master_readdata;
  logic                    master_readdatavalid;
  logic                    master_waitrequest;
  // Status
  logic                    timeout_err;

  modport master (
    input  r0_address, r0_writedata, r0_write, r0_read,
    output r0_waitrequest, r0_readdata, r0_readdatavalid,
    input  r1_address, r1_writedata, r1_write, r1_read,
    output r1_waitrequest, r1_readdata, r1_readdatavalid,
    output master_address, master_writedata, master_write, master_read,
    input  master_readdata, master_readdatavalid, master_waitrequest,
    output timeout_err
  );

  modport slave (
    output r0_address, r0_writedata, r0_write, r0_read,
    input  r0_waitrequest, r0_readdata, r0_readdatavalid,
    output r1_address, r1_writedata, r1_write, r1_read,
    input  r1_waitrequest, r1_readdata, r1_readdatavalid,
    input  master_address, master_writedata, master_write, master_read,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input  timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/amm_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : amm_master_arbiter
// Summary  : Round-robin arbiter sharing one Avalon-MM master port between
//            two requesters, one transaction in flight at a time, with a
//            read-response timeout that forces completion on a hung slave.
// Revision : 1.0 - initial release
// ============================================================================
module amm_master_arbiter #(
  parameter int                   ADDRESSWIDTH   = 26,
  parameter int                   DATAWIDTH      = 32,
  parameter int                   TIMEOUT_CYCLES = 255,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  amm_master_arbiter_if.master    bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Owner-selected request view; a simultaneous read+write is treated as a write
  logic                    req0, req1;
  logic [ADDRESSWIDTH-1:0] own_address;
  logic [DATAWIDTH-1:0]    own_writedata;
  logic                    own_write;
  logic                    own_read;

  assign req0          = bus.r0_read | bus.r0_write;
  assign req1          = bus.r1_read | bus.r1_write;
  assign own_address   = owner_q ? bus.r1_address   : bus.r0_address;
  assign own_writedata = owner_q ? bus.r1_writedata : bus.r0_writedata;
  assign own_write     = owner_q ? bus.r1_write     : bus.r0_write;
  assign own_read      = (owner_q ? bus.r1_read : bus.r0_read) & ~own_write;

  // State register: synchronous active-low reset abandons any in-flight read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: round-robin grant, acceptance tracking, read timeout
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          if (req0 & req1) begin
            owner_d = ~last_grant_q;
          end else begin
            owner_d = req1;
          end
          last_grant_d = owner_d;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (!own_write && !own_read) begin
          // Requester withdrew before acceptance: release the bus silently
          state_d = IDLE;
        end else if (!bus.master_waitrequest) begin
          if (own_write) begin
            state_d = IDLE;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = '0;
          end
        end
      end
      RD_WAIT: begin
        if (bus.master_readdatavalid || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: bus mirrors owner in GRANT, responses routed to owner only
  logic [ADDRESSWIDTH-1:0] m_address;
  logic [DATAWIDTH-1:0]    m_writedata;
  logic                    m_write;
  logic                    m_read;
  logic [1:0]              waitreq;
  logic [1:0]              rdvalid;
  logic [DATAWIDTH-1:0]    rdata;
  logic                    tmo;

  always_comb begin
    m_address   = '0;
    m_writedata = '0;
    m_write     = 1'b0;
    m_read      = 1'b0;
    waitreq     = 2'b11;
    rdvalid     = 2'b00;
    rdata       = '0;
    tmo         = 1'b0;
    // Outputs are held at reset values while reset_n is low so nothing
    // from an abandoned transaction can leak out during the reset cycle
    if (reset_n) begin
      case (state_q)
        GRANT: begin
          m_address        = own_address;
          m_writedata      = own_writedata;
          m_write          = own_write;
          m_read           = own_read;
          waitreq[owner_q] = bus.master_waitrequest;
        end
        RD_WAIT: begin
          if (bus.master_readdatavalid) begin
            rdvalid[owner_q] = 1'b1;
            rdata            = bus.master_readdata;
          end else if (cnt_q == CNT_LAST) begin
            rdvalid[owner_q] = 1'b1;
            rdata            = TIMEOUT_DATA;
            tmo              = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.master_address   = m_address;
  assign bus.master_writedata = m_writedata;
  assign bus.master_write     = m_write;
  assign bus.master_read      = m_read;
  assign bus.r0_waitrequest   = waitreq[0];
  assign bus.r1_waitrequest   = waitreq[1];
  assign bus.r0_readdatavalid = rdvalid[0];
  assign bus.r1_readdatavalid = rdvalid[1];
  assign bus.r0_readdata      = rdvalid[0] ? rdata : '0;
  assign bus.r1_readdata      = rdvalid[1] ? rdata : '0;
  assign bus.timeout_err      = tmo;

endmodule
`default_nettype wire

// File: tb/tb_amm_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_amm_master_arbiter
// Summary  : Directed, scoreboard-checked bench for amm_master_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amm_master_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_RDV = 2;

  typedef struct {
    int            kind;
    bit            who;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            to;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  amm_master_arbiter_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus();

  amm_master_arbiter #(
    .ADDRESSWIDTH  (AW),
    .DATAWIDTH     (DW),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (32'hDEADDEAD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int kind, input bit who, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit to);
    exp_t e;
    e.kind = kind; e.who = who; e.addr = a; e.data = d; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit who, input bit wr, input bit rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!who) begin
      bus.r0_write = wr; bus.r0_read = rd; bus.r0_address = a; bus.r0_writedata = d;
    end else begin
      bus.r1_write = wr; bus.r1_read = rd; bus.r1_address = a; bus.r1_writedata = d;
    end
  endtask

  // Requester model: hold the request until its waitrequest is seen low
  task automatic txn(input bit who, input bit wr, input bit rd,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    int  n;
    logic w;
    drive(who, wr, rd, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      w = who ? bus.r1_waitrequest : bus.r0_waitrequest;
    end while (w && n < 50);
    chk(who ? "accept_r1" : "accept_r0", w, 0);
    cyc();
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_mwrite"}, bus.master_write, 0);
    chk({p, "_mread"},  bus.master_read, 0);
    chk({p, "_maddr"},  bus.master_address, 0);
    chk({p, "_mwdata"}, bus.master_writedata, 0);
    chk({p, "_r0wait"}, bus.r0_waitrequest, 1);
    chk({p, "_r1wait"}, bus.r1_waitrequest, 1);
    chk({p, "_r0rdv"},  bus.r0_readdatavalid, 0);
    chk({p, "_r1rdv"},  bus.r1_readdatavalid, 0);
    chk({p, "_rdata"},  {bus.r0_readdata, bus.r1_readdata}, 0);
    chk({p, "_tmo"},    bus.timeout_err, 0);
  endtask

  task automatic do_reset(input string p);
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle(p);
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a bus command
  // acceptance or a read response, and compare against the expectation
  always @(negedge clk) begin
    if ((bus.master_write || bus.master_read) && !bus.master_waitrequest) begin
      chk("bus_evt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("bus_kind", bus.master_write ? K_WR : K_RD, mon_e.kind);
        chk("bus_addr", bus.master_address, mon_e.addr);
        if (mon_e.kind == K_WR) begin
          chk("bus_wdata", bus.master_writedata, mon_e.data);
          chk("bus_no_read", bus.master_read, 0);
        end
        chk("owner_wait", mon_e.who ? bus.r1_waitrequest : bus.r0_waitrequest, 0);
        chk("other_wait", mon_e.who ? bus.r0_waitrequest : bus.r1_waitrequest, 1);
      end
    end
    if (bus.r0_readdatavalid || bus.r1_readdatavalid) begin
      chk("rdv_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rdv_expected_kind", mon_e.kind, K_RDV);
        chk("rdv_owner", bus.r1_readdatavalid, mon_e.who);
        chk("rdv_single", bus.r0_readdatavalid & bus.r1_readdatavalid, 0);
        chk("rdv_data", mon_e.who ? bus.r1_readdata : bus.r0_readdata, mon_e.data);
        chk("rdv_timeout", bus.timeout_err, mon_e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required earlier finish");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    bus.master_readdata      = '0;
    bus.master_readdatavalid = 1'b0;
    bus.master_waitrequest   = 1'b0;

    // Reset then single r0 write with zero wait
    do_reset("rst0");
    cyc();
    drive(0, 1, 0, 'h10, 32'hA5A5A5A5);
    expect_evt(K_WR, 0, 'h10, 32'hA5A5A5A5, 0);
    @(negedge clk);
    chk("t1_idle_mwrite", bus.master_write, 0);
    chk("t1_idle_r0wait", bus.r0_waitrequest, 1);
    cyc();
    @(negedge clk);
    chk("t1_mwrite", bus.master_write, 1);
    chk("t1_maddr", bus.master_address, 'h10);
    chk("t1_mwdata", bus.master_writedata, 32'hA5A5A5A5);
    chk("t1_r0wait", bus.r0_waitrequest, 0);
    chk("t1_r1wait", bus.r1_waitrequest, 1);
    cyc();
    drive(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t1_post_mwrite", bus.master_write, 0);

    // Both requesters writing continuously: grants alternate r0,r1,r0,r1
    do_reset("rst1");
    cyc();
    expect_evt(K_WR, 0, 'h100, 32'hA0, 0);
    expect_evt(K_WR, 1, 'h101, 32'hA1, 0);
    expect_evt(K_WR, 0, 'h102, 32'hA2, 0);
    expect_evt(K_WR, 1, 'h103, 32'hA3, 0);
    fork
      begin
        txn(0, 1, 0, 'h100, 32'hA0);
        txn(0, 1, 0, 'h102, 32'hA2);
        drive(0, 0, 0, '0, '0);
      end
      begin
        txn(1, 1, 0, 'h101, 32'hA1);
        txn(1, 1, 0, 'h103, 32'hA3);
        drive(1, 0, 0, '0, '0);
      end
    join
    cyc();

    // r1 read stalled 3 cycles, data returns 2 cycles after acceptance
    drive(1, 0, 1, 'h20, '0);
    bus.master_waitrequest = 1'b1;
    expect_evt(K_RD, 1, 'h20, '0, 0);
    expect_evt(K_RDV, 1, '0, 32'h12345678, 0);
    cyc();
    @(negedge clk);
    chk("t3_stall_mread", bus.master_read, 1);
    chk("t3_stall_maddr", bus.master_address, 'h20);
    chk("t3_stall_r1wait", bus.r1_waitrequest, 1);
    chk("t3_stall_r0wait", bus.r0_waitrequest, 1);
    cyc();
    cyc();
    cyc();
    bus.master_waitrequest = 1'b0;
    cyc();
    drive(1, 0, 0, '0, '0);
    cyc();
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata      = 32'h12345678;
    @(negedge clk);
    chk("t3_r1rdv", bus.r1_readdatavalid, 1);
    chk("t3_r0rdv", bus.r0_readdatavalid, 0);
    cyc();
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata      = '0;

    // r0 read with no response: timeout in the 8th RD_WAIT cycle
    cyc();
    drive(0, 0, 1, 'h30, '0);
    expect_evt(K_RD, 0, 'h30, '0, 0);
    expect_evt(K_RDV, 0, '0, 32'hDEADDEAD, 1);
    cyc();
    cyc();
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_early_rdv", bus.r0_readdatavalid, 0);
      chk("t4_early_tmo", bus.timeout_err, 0);
      cyc();
    end
    @(negedge clk);
    chk("t4_to_rdv", bus.r0_readdatavalid, 1);
    chk("t4_to_err", bus.timeout_err, 1);
    chk("t4_to_data", bus.r0_readdata, 32'hDEADDEAD);
    cyc();
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata      = 32'hBAD;
    @(negedge clk);
    chk("t4_stray_r0rdv", bus.r0_readdatavalid, 0);
    chk("t4_stray_r1rdv", bus.r1_readdatavalid, 0);
    chk("t4_tmo_pulse", bus.timeout_err, 0);
    cyc();
    bus.master_readdatavalid = 1'b0;

    // Reset for one cycle while in RD_WAIT
    drive(0, 0, 1, 'h40, '0);
    expect_evt(K_RD, 0, 'h40, '0, 0);
    cyc();
    cyc();
    drive(0, 0, 0, '0, '0);
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("t5_rst");
    cyc();
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata      = 32'h55;
    @(negedge clk);
    chk("t5_late_r0rdv", bus.r0_readdatavalid, 0);
    cyc();
    bus.master_readdatavalid = 1'b0;
    drive(1, 1, 0, 'h50, 32'hCAFE);
    expect_evt(K_WR, 1, 'h50, 32'hCAFE, 0);
    cyc();
    @(negedge clk);
    chk("t5_r1_mwrite", bus.master_write, 1);
    chk("t5_r1_maddr", bus.master_address, 'h50);
    cyc();
    drive(1, 0, 0, '0, '0);

    // Read and write together: write wins, no RD_WAIT
    drive(0, 1, 1, 'h4, 32'h77);
    expect_evt(K_WR, 0, 'h4, 32'h77, 0);
    cyc();
    @(negedge clk);
    chk("t6_mwrite", bus.master_write, 1);
    chk("t6_mread", bus.master_read, 0);
    cyc();
    drive(0, 0, 0, '0, '0);
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata      = 32'h99;
    @(negedge clk);
    chk("t6_no_rdwait_rdv", bus.r0_readdatavalid, 0);
    cyc();
    bus.master_readdatavalid = 1'b0;
    cyc();
    cyc();

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
